// File: rtl/iir_coef_sched_pkg.sv
// Shared types and constants for the biquad coefficient scheduler and the IIR datapath.
// Coefficients are two's complement Q2.14.
package iir_coef_pkg;

   localparam int COEF_W   = 16;
   localparam int NUM_COEF = 5;

   localparam logic [2:0] IDX_A0 = 3'd0;
   localparam logic [2:0] IDX_A1 = 3'd1;
   localparam logic [2:0] IDX_A2 = 3'd2;
   localparam logic [2:0] IDX_B1 = 3'd3;
   localparam logic [2:0] IDX_B2 = 3'd4;

   typedef logic signed [COEF_W-1:0] coef_t;

   localparam coef_t ONE = 16'sh4000;

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_e;

   function automatic logic addr_valid(input logic [2:0] addr);
      return addr <= 3'(NUM_COEF - 1);
   endfunction

endpackage

// File: rtl/iir_coef_sched_fs_edge_sync.sv
// Two-flop synchronizer for the sample clock plus rising-edge detect.
// Same structure as the datapath's own detector so both see the identical edge.
module fs_edge_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic async_i,
   output logic rise_o
);

   logic fs_d1_q;
   logic fs_d2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fs_d1_q <= 1'b0;
         fs_d2_q <= 1'b0;
      end else begin
         fs_d1_q <= async_i;
         fs_d2_q <= fs_d1_q;
      end
   end

   assign rise_o = fs_d1_q & ~fs_d2_q;

endmodule

// File: rtl/iir_coef_sched.sv
// Shadow/active coefficient banks for the biquad IIR; a committed shadow bank is
// copied to the active bank in one edge at the next sample boundary (or on timeout).
module iir_coef_sched
   import iir_coef_pkg::*;
#(
   parameter int    TIMEOUT_CYC = 1024,
   parameter coef_t DEF_A0      = ONE,
   parameter coef_t DEF_A1      = 16'sh0000,
   parameter coef_t DEF_A2      = 16'sh0000,
   parameter coef_t DEF_B1      = 16'sh0000,
   parameter coef_t DEF_B2      = 16'sh0000
) (
   input  logic        MCLK,
   input  logic        RST,
   input  logic        FSCLK,
   input  logic        WR_EN,
   input  logic [2:0]  WR_ADDR,
   input  logic [15:0] WR_DATA,
   input  logic        WR_COMMIT,
   input  logic        ERR_CLR,
   output logic        WR_READY,
   output logic        COMMIT_DONE,
   output logic        WR_ERR,
   output logic        TO_FLAG,
   output logic [15:0] A0,
   output logic [15:0] A1,
   output logic [15:0] A2,
   output logic [15:0] B1,
   output logic [15:0] B2
);

   localparam logic [15:0] TCNT_LAST = 16'(TIMEOUT_CYC - 1);
   localparam coef_t DEF_BANK [NUM_COEF] = '{DEF_A0, DEF_A1, DEF_A2, DEF_B1, DEF_B2};

   logic        fs_rise;
   state_e      state_q, state_d;
   logic [15:0] tcnt_q, tcnt_d;
   coef_t       shadow_q [NUM_COEF];
   coef_t       shadow_d [NUM_COEF];
   coef_t       active_q [NUM_COEF];
   coef_t       active_d [NUM_COEF];
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        to_q, to_d;
   logic        err_set;

   fs_edge_sync u_fs_sync (
      .clk_i   (MCLK),
      .rst_i   (RST),
      .async_i (FSCLK),
      .rise_o  (fs_rise)
   );

   always_comb begin
      state_d  = state_q;
      tcnt_d   = tcnt_q;
      shadow_d = shadow_q;
      active_d = active_q;
      done_d   = 1'b0;
      err_set  = 1'b0;
      to_d     = to_q & ~ERR_CLR;

      case (state_q)
         IDLE: begin
            // A write sharing a cycle with the commit lands in the shadow on this
            // edge, so the later swap (which reads shadow_q) carries it.
            if (WR_EN) begin
               if (addr_valid(WR_ADDR)) begin
                  shadow_d[WR_ADDR] = coef_t'(WR_DATA);
               end else begin
                  err_set = 1'b1;
               end
            end
            if (WR_COMMIT) begin
               state_d = PEND;
               tcnt_d  = '0;
            end
         end
         PEND: begin
            if (WR_EN || WR_COMMIT) begin
               err_set = 1'b1;
            end
            if (fs_rise || (tcnt_q == TCNT_LAST)) begin
               active_d = shadow_q;
               done_d   = 1'b1;
               state_d  = IDLE;
               tcnt_d   = '0;
               if (!fs_rise) begin
                  to_d = 1'b1;
               end
            end else begin
               tcnt_d = tcnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new error in the same cycle as ERR_CLR keeps the flag set.
      err_d = err_set | (err_q & ~ERR_CLR);
   end

   always_ff @(posedge MCLK) begin
      if (RST) begin
         state_q  <= IDLE;
         tcnt_q   <= '0;
         shadow_q <= DEF_BANK;
         active_q <= DEF_BANK;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         tcnt_q   <= tcnt_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         done_q   <= done_d;
         err_q    <= err_d;
         to_q     <= to_d;
      end
   end

   assign WR_READY    = (state_q == IDLE);
   assign COMMIT_DONE = done_q;
   assign WR_ERR      = err_q;
   assign TO_FLAG     = to_q;
   assign A0          = active_q[IDX_A0];
   assign A1          = active_q[IDX_A1];
   assign A2          = active_q[IDX_A2];
   assign B1          = active_q[IDX_B1];
   assign B2          = active_q[IDX_B2];

endmodule

// File: tb/tb_iir_coef_sched.sv
// Directed bench for iir_coef_sched with TIMEOUT_CYC=8.
module tb_iir_coef_sched;

   logic        MCLK = 1'b0;
   logic        RST = 1'b1;
   logic        FSCLK = 1'b0;
   logic        WR_EN = 1'b0;
   logic [2:0]  WR_ADDR = 3'd0;
   logic [15:0] WR_DATA = 16'h0000;
   logic        WR_COMMIT = 1'b0;
   logic        ERR_CLR = 1'b0;
   logic        WR_READY, COMMIT_DONE, WR_ERR, TO_FLAG;
   logic [15:0] A0, A1, A2, B1, B2;

   int n_tests = 0;
   int n_fail  = 0;

   iir_coef_sched #(.TIMEOUT_CYC(8)) dut (
      .MCLK        (MCLK),
      .RST         (RST),
      .FSCLK       (FSCLK),
      .WR_EN       (WR_EN),
      .WR_ADDR     (WR_ADDR),
      .WR_DATA     (WR_DATA),
      .WR_COMMIT   (WR_COMMIT),
      .ERR_CLR     (ERR_CLR),
      .WR_READY    (WR_READY),
      .COMMIT_DONE (COMMIT_DONE),
      .WR_ERR      (WR_ERR),
      .TO_FLAG     (TO_FLAG),
      .A0          (A0),
      .A1          (A1),
      .A2          (A2),
      .B1          (B1),
      .B2          (B2)
   );

   always #5 MCLK = ~MCLK;

   task automatic tick();
      @(posedge MCLK);
      #1;
   endtask

   task automatic write_word(input logic [2:0] addr, input logic [15:0] data);
      WR_EN = 1'b1; WR_ADDR = addr; WR_DATA = data;
      tick();
      WR_EN = 1'b0;
   endtask

   task automatic fs_low();
      FSCLK = 1'b0;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (2) tick();
      RST = 1'b0;
      n_tests++;
      if ({A0, A1, A2, B1, B2} !== {16'h4000, 16'h0, 16'h0, 16'h0, 16'h0}) begin
         n_fail++; $display("FAIL reset_coefs: got %h %h %h %h %h exp 4000 0 0 0 0", A0, A1, A2, B1, B2);
      end
      n_tests++;
      if ({WR_READY, COMMIT_DONE, WR_ERR, TO_FLAG} !== 4'b1000) begin
         n_fail++; $display("FAIL reset_flags: got %b exp 1000", {WR_READY, COMMIT_DONE, WR_ERR, TO_FLAG});
      end
      // Reset in the middle of a pending commit
      write_word(3'd0, 16'h1111);
      WR_COMMIT = 1'b1; tick(); WR_COMMIT = 1'b0;
      n_tests++;
      if (WR_READY !== 1'b0) begin
         n_fail++; $display("FAIL pend_ready: got %b exp 0", WR_READY);
      end
      RST = 1'b1; tick(); RST = 1'b0;
      n_tests++;
      if ({A0, WR_READY, COMMIT_DONE, WR_ERR, TO_FLAG} !== {16'h4000, 4'b1000}) begin
         n_fail++; $display("FAIL midpend_reset: got A0=%h flags=%b exp A0=4000 flags=1000", A0, {WR_READY, COMMIT_DONE, WR_ERR, TO_FLAG});
      end
      FSCLK = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (COMMIT_DONE !== 1'b0 || A0 !== 16'h4000) begin
            n_fail++; $display("FAIL no_swap_after_reset[%0d]: got done=%b A0=%h exp done=0 A0=4000", i, COMMIT_DONE, A0);
         end
      end
      fs_low();
   endtask

   task automatic test_atomic_swap();
      int pulses;
      write_word(3'd0, 16'h2000);
      write_word(3'd3, 16'hC000);
      WR_COMMIT = 1'b1; tick(); WR_COMMIT = 1'b0;
      FSCLK = 1'b1;
      tick();  // edge e: fs_rise now high
      n_tests++;
      if (A0 !== 16'h4000 || B1 !== 16'h0000 || COMMIT_DONE !== 1'b0 || WR_READY !== 1'b0) begin
         n_fail++; $display("FAIL swap_early: got A0=%h B1=%h done=%b rdy=%b exp 4000 0000 0 0", A0, B1, COMMIT_DONE, WR_READY);
      end
      tick();  // edge e+1
      n_tests++;
      if (A0 !== 16'h2000 || B1 !== 16'hC000 || COMMIT_DONE !== 1'b1 || WR_READY !== 1'b1 || TO_FLAG !== 1'b0) begin
         n_fail++; $display("FAIL swap_edge: got A0=%h B1=%h done=%b rdy=%b to=%b exp 2000 c000 1 1 0", A0, B1, COMMIT_DONE, WR_READY, TO_FLAG);
      end
      pulses = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (COMMIT_DONE === 1'b1) pulses++;
      end
      n_tests++;
      if (pulses != 1) begin
         n_fail++; $display("FAIL done_pulse_count: got %0d exp 1", pulses);
      end
      fs_low();
   endtask

   task automatic test_write_in_pend();
      WR_COMMIT = 1'b1; tick(); WR_COMMIT = 1'b0;
      write_word(3'd1, 16'h1234);
      n_tests++;
      if (WR_ERR !== 1'b1 || WR_READY !== 1'b0) begin
         n_fail++; $display("FAIL pend_write_err: got err=%b rdy=%b exp 1 0", WR_ERR, WR_READY);
      end
      FSCLK = 1'b1;
      repeat (2) tick();
      n_tests++;
      if (COMMIT_DONE !== 1'b1 || A1 !== 16'h0000 || A0 !== 16'h2000 || TO_FLAG !== 1'b0) begin
         n_fail++; $display("FAIL pend_swap_old_a1: got done=%b A1=%h A0=%h to=%b exp 1 0000 2000 0", COMMIT_DONE, A1, A0, TO_FLAG);
      end
      fs_low();
      WR_COMMIT = 1'b1; tick(); WR_COMMIT = 1'b0;
      FSCLK = 1'b1;
      repeat (2) tick();
      n_tests++;
      if (COMMIT_DONE !== 1'b1 || A1 !== 16'h0000) begin
         n_fail++; $display("FAIL shadow_a1_kept: got done=%b A1=%h exp 1 0000", COMMIT_DONE, A1);
      end
      fs_low();
      ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
      n_tests++;
      if (WR_ERR !== 1'b0) begin
         n_fail++; $display("FAIL err_clr: got %b exp 0", WR_ERR);
      end
   endtask

   task automatic test_same_cycle();
      WR_EN = 1'b1; WR_ADDR = 3'd2; WR_DATA = 16'h0800; WR_COMMIT = 1'b1;
      tick();
      WR_EN = 1'b0; WR_COMMIT = 1'b0;
      n_tests++;
      if (WR_READY !== 1'b0 || WR_ERR !== 1'b0) begin
         n_fail++; $display("FAIL same_cycle_accept: got rdy=%b err=%b exp 0 0", WR_READY, WR_ERR);
      end
      FSCLK = 1'b1;
      repeat (2) tick();
      n_tests++;
      if (COMMIT_DONE !== 1'b1 || A2 !== 16'h0800 || B1 !== 16'hC000) begin
         n_fail++; $display("FAIL same_cycle_swap: got done=%b A2=%h B1=%h exp 1 0800 c000", COMMIT_DONE, A2, B1);
      end
      fs_low();
   endtask

   task automatic test_timeout();
      write_word(3'd4, 16'h7FFF);
      WR_COMMIT = 1'b1; tick(); WR_COMMIT = 1'b0;  // edge t0
      for (int i = 1; i < 8; i++) begin
         tick();
         n_tests++;
         if (COMMIT_DONE !== 1'b0 || B2 !== 16'h0000) begin
            n_fail++; $display("FAIL timeout_early[t0+%0d]: got done=%b B2=%h exp 0 0000", i, COMMIT_DONE, B2);
         end
      end
      tick();  // t0+8
      n_tests++;
      if (COMMIT_DONE !== 1'b1 || TO_FLAG !== 1'b1 || B2 !== 16'h7FFF || WR_READY !== 1'b1) begin
         n_fail++; $display("FAIL timeout_swap: got done=%b to=%b B2=%h rdy=%b exp 1 1 7fff 1", COMMIT_DONE, TO_FLAG, B2, WR_READY);
      end
      repeat (3) tick();
      n_tests++;
      if (TO_FLAG !== 1'b1) begin
         n_fail++; $display("FAIL to_sticky: got %b exp 1", TO_FLAG);
      end
      ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0;
      n_tests++;
      if (TO_FLAG !== 1'b0 || WR_ERR !== 1'b0) begin
         n_fail++; $display("FAIL to_clr: got to=%b err=%b exp 0 0", TO_FLAG, WR_ERR);
      end
      ERR_CLR = 1'b1;
      write_word(3'd6, 16'hAAAA);
      ERR_CLR = 1'b0;
      n_tests++;
      if (WR_ERR !== 1'b1 || TO_FLAG !== 1'b0) begin
         n_fail++; $display("FAIL clr_vs_set: got err=%b to=%b exp 1 0", WR_ERR, TO_FLAG);
      end
      // Dropped out-of-range write must not touch any bank word
      FSCLK = 1'b1;
      WR_COMMIT = 1'b1; tick(); WR_COMMIT = 1'b0;
      repeat (2) tick();
      n_tests++;
      if ({A0, A1, A2, B1, B2} !== {16'h2000, 16'h0000, 16'h0800, 16'hC000, 16'h7FFF}) begin
         n_fail++; $display("FAIL bank_after_bad_addr: got %h %h %h %h %h exp 2000 0000 0800 c000 7fff", A0, A1, A2, B1, B2);
      end
      fs_low();
   endtask

   initial begin
      test_reset();
      test_atomic_swap();
      test_write_in_pend();
      test_same_cycle();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
